// File: rtl/multi_delay_gen_pkg.sv
// Shared types and default sizing for the multi-channel delayed-enable generator.
// Optional feature: MULTI_DELAY_GEN_RTC_SYNC_EN (see multi_delay_gen.sv).
package multi_delay_gen_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        ON_WAIT,
        ON,
        OFF_WAIT
    } ch_state_e;

endpackage

// File: rtl/multi_delay_gen_ch.sv
// One delayed-enable channel: on/off delay FSM with a tick-driven down-counter.
// Optional feature: none in this file (MULTI_DELAY_GEN_RTC_SYNC_EN lives in the top).
module delay_gen_ch
    import multi_delay_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] delay_on_i,
    input  logic [CNT_W-1:0] delay_off_i,
    output logic             en_o,
    output logic             busy_o
);

    ch_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             last;

    assign last = (cnt == CNT_W'(1));

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // en_i is tested before tick_i so an en_i change always wins over a tick
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (en_i) begin
                    if (delay_on_i == '0) begin
                        state_n = ON;
                    end else begin
                        state_n = ON_WAIT;
                        cnt_n   = delay_on_i;
                    end
                end
            end
            ON_WAIT: begin
                if (!en_i) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (tick_i) begin
                    if (last) begin
                        state_n = ON;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            ON: begin
                if (!en_i) begin
                    if (delay_off_i == '0) begin
                        state_n = IDLE;
                    end else begin
                        state_n = OFF_WAIT;
                        cnt_n   = delay_off_i;
                    end
                end
            end
            OFF_WAIT: begin
                if (en_i) begin
                    state_n = ON;
                    cnt_n   = '0;
                end else if (tick_i) begin
                    if (last) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign en_o   = (state == ON) || (state == OFF_WAIT);
    assign busy_o = (state == ON_WAIT) || (state == OFF_WAIT);

endmodule

// File: rtl/multi_delay_gen.sv
// Multi-channel delayed-enable generator sharing one rtc-derived tick.
// Define MULTI_DELAY_GEN_RTC_SYNC_EN to add a 2-flop synchroniser on rtc_i.
module multi_delay_gen
    import multi_delay_gen_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                         clk_i,
    input  logic                         arst_i,
    input  logic                         rtc_i,
    input  logic [NUM_CH-1:0]            en_i,
    input  logic [NUM_CH-1:0][CNT_W-1:0] delay_on_i,
    input  logic [NUM_CH-1:0][CNT_W-1:0] delay_off_i,
    output logic [NUM_CH-1:0]            en_o,
    output logic [NUM_CH-1:0]            busy_o
);

    logic rtc_s;
    logic rtc_d;
    logic tick;

`ifdef MULTI_DELAY_GEN_RTC_SYNC_EN
    logic [1:0] rtc_sync;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rtc_sync <= '0;
        end else begin
            rtc_sync <= {rtc_sync[0], rtc_i};
        end
    end

    assign rtc_s = rtc_sync[1];
`else
    assign rtc_s = rtc_i;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rtc_d <= 1'b0;
        end else begin
            rtc_d <= rtc_s;
        end
    end

    assign tick = rtc_s & ~rtc_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        delay_gen_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i      (clk_i),
            .arst_i     (arst_i),
            .tick_i     (tick),
            .en_i       (en_i[g]),
            .delay_on_i (delay_on_i[g]),
            .delay_off_i(delay_off_i[g]),
            .en_o       (en_o[g]),
            .busy_o     (busy_o[g])
        );
    end

endmodule
